// File: rtl/noc_params.sv
// Shared NoC parameters and flit type used by routers and inter-router link stages.
package noc_params;

    localparam int VC_NUM_DEFAULT          = 2;
    localparam int VC_SIZE                 = (VC_NUM_DEFAULT > 1) ? $clog2(VC_NUM_DEFAULT) : 1;
    localparam int DATA_SIZE               = 32;
    localparam int LINK_STAGES_DEFAULT     = 2;
    localparam int LINK_SKID_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [VC_SIZE-1:0]     vc_id;
        logic [DATA_SIZE-1:0]   data;
    } flit_t;

endpackage

// File: rtl/link_skid_fifo.sv
// Single-VC circular skid FIFO; a separate occupancy counter tells full from empty.
module link_skid_fifo
    import noc_params::*;
#(
    parameter int DEPTH = LINK_SKID_DEPTH_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  flit_t din,
    output flit_t head,
    output logic  full,
    output logic  empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    flit_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop frees the slot first, so a full FIFO still accepts a same-cycle push
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/link_retimer.sv
// Pipelined router-to-router link: retimed flits into per-VC skid FIFOs, with
// on_off / is_allocatable regenerated toward the upstream router.
module link_retimer
    import noc_params::*;
#(
    parameter int VC_NUM      = VC_NUM_DEFAULT,
    parameter int LINK_STAGES = LINK_STAGES_DEFAULT,
    parameter int SKID_DEPTH  = LINK_SKID_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             up_data_i,
    input  logic              up_valid_i,
    output logic [VC_NUM-1:0] up_on_off_o,
    output logic [VC_NUM-1:0] up_is_allocatable_o,
    output flit_t             dn_data_o,
    output logic              dn_valid_o,
    input  logic [VC_NUM-1:0] dn_on_off_i,
    input  logic [VC_NUM-1:0] dn_is_allocatable_i,
    output logic              overflow_o
);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int LAST  = LINK_STAGES - 1;

    flit_t                  fwd_data   [LINK_STAGES];
    logic [LINK_STAGES-1:0] fwd_valid;
    logic [VC_NUM-1:0]      alloc_pipe [LINK_STAGES];

    logic [CNT_W-1:0]       cnt        [VC_NUM];
    logic [CNT_W-1:0]       cnt_next   [VC_NUM];
    logic [VC_NUM-1:0]      on_off_next;
    logic [VC_NUM-1:0]      inc;
    logic [VC_NUM-1:0]      push;
    logic [VC_NUM-1:0]      pop;
    logic [VC_NUM-1:0]      drop;
    logic [VC_NUM-1:0]      full;
    logic [VC_NUM-1:0]      empty;
    logic [VC_NUM-1:0]      eligible;
    flit_t                  head       [VC_NUM];

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       rr_ptr_next;
    logic [PTR_W-1:0]       idx;
    logic [PTR_W-1:0]       winner;
    logic                   any_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < LINK_STAGES; s++) begin
                fwd_data[s]   <= '0;
                alloc_pipe[s] <= '1;
            end
            fwd_valid <= '0;
        end else begin
            fwd_data[0]   <= up_data_i;
            fwd_valid[0]  <= up_valid_i;
            alloc_pipe[0] <= dn_is_allocatable_i;
            for (int unsigned s = 1; s < LINK_STAGES; s++) begin
                fwd_data[s]   <= fwd_data[s-1];
                fwd_valid[s]  <= fwd_valid[s-1];
                alloc_pipe[s] <= alloc_pipe[s-1];
            end
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        link_skid_fifo #(
            .DEPTH (SKID_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (fwd_data[LAST]),
            .head  (head[v]),
            .full  (full[v]),
            .empty (empty[v])
        );
    end

    assign eligible = ~empty & dn_on_off_i;

    always_comb begin
        winner  = '0;
        idx     = '0;
        any_win = 1'b0;
        pop     = '0;
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % VC_NUM);
            if (!any_win && eligible[idx]) begin
                winner  = idx;
                any_win = 1'b1;
            end
        end
        if (any_win) begin
            pop[winner] = 1'b1;
        end
        rr_ptr_next = any_win ? PTR_W'((32'(winner) + 1) % VC_NUM) : rr_ptr;
    end

    // dropped flits leave the link too, so they are discounted like pops
    always_comb begin
        push        = '0;
        inc         = '0;
        drop        = '0;
        on_off_next = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            push[v] = fwd_valid[LAST] && (fwd_data[LAST].vc_id == VC_SIZE'(v));
            inc[v]  = up_valid_i && (up_data_i.vc_id == VC_SIZE'(v));
            drop[v] = push[v] && full[v] && !pop[v];
            cnt_next[v] = cnt[v];
            if (inc[v] && !(pop[v] || drop[v]) && (cnt[v] != '1)) begin
                cnt_next[v] = cnt[v] + 1'b1;
            end else if (!inc[v] && (pop[v] || drop[v])) begin
                cnt_next[v] = cnt[v] - 1'b1;
            end
            on_off_next[v] = (32'(cnt_next[v]) + 32'd2) < 32'(SKID_DEPTH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                cnt[v] <= '0;
            end
            rr_ptr              <= '0;
            up_on_off_o         <= '1;
            up_is_allocatable_o <= '1;
            dn_valid_o          <= 1'b0;
            dn_data_o           <= '0;
            overflow_o          <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                cnt[v]                 <= cnt_next[v];
                up_is_allocatable_o[v] <= alloc_pipe[LAST][v] && (cnt[v] == '0);
            end
            rr_ptr      <= rr_ptr_next;
            up_on_off_o <= on_off_next;
            dn_valid_o  <= any_win;
            if (any_win) begin
                dn_data_o <= head[winner];
            end
            if (|drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/link_retimer.md
Name: link_retimer

Overview:
- Parametrised inter-router link stage. It sits between one router output port and the neighbour's input port on the router2router connection.
- Forward path: LINK_STAGES of flit/valid retiming, followed by a per-VC skid FIFO.
- Reverse path: regenerates on_off and is_allocatable toward the upstream router, so link latency never causes downstream buffer overflow.
- Lets mesh links be pipelined for timing, which the current direct router-to-router wiring does not support.

Parameters:
- VC_NUM, 2, virtual channels per port; must match the router's VC_NUM.
- LINK_STAGES, 2, forward and reverse register stages; range 1..8.
- SKID_DEPTH, 8, flits per VC skid FIFO; must be >= LINK_STAGES+4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- up_data_i  in  flit_t  flit from the upstream router output.
- up_valid_i  in  1  up_data_i valid.
- up_on_off_o  out  VC_NUM  per-VC on/off back to upstream.
- up_is_allocatable_o  out  VC_NUM  per-VC allocatable back to upstream.
- dn_data_o  out  flit_t  flit to the downstream input block.
- dn_valid_o  out  1  dn_data_o valid.
- dn_on_off_i  in  VC_NUM  downstream per-VC on/off.
- dn_is_allocatable_i  in  VC_NUM  downstream per-VC allocatable.
- overflow_o  out  1  sticky error: a flit arrived at a full skid FIFO.

Behaviour:
- Reset (rst=0, async):
  - All stage registers, FIFOs and counters cleared.
  - dn_valid_o=0, dn_data_o='0, overflow_o=0.
  - up_on_off_o=all 1, up_is_allocatable_o=all 1.
  - Reverse is_allocatable pipeline resets to all 1; round-robin pointer resets to 0.
  - Reset mid-traffic discards all in-flight flits; no partial flit appears after deassertion.
- Forward pipeline:
  - up_valid_i/up_data_i pass through LINK_STAGES registers; valid bubbles propagate unchanged.
  - At the pipeline exit, a valid flit is pushed into FIFO[flit.vc_id].
- Occupancy count per VC:
  - cnt[v] = flits for VC v in the forward pipeline + FIFO[v] occupancy.
  - Incremented when up_valid_i carries vc_id=v; decremented when VC v is popped to the output.
  - Both in one cycle leave it unchanged.
  - Width $clog2(SKID_DEPTH+1); cnt never exceeds SKID_DEPTH in legal operation.
- up_on_off_o[v]:
  - Registered; next value = (cnt_next[v] + 2 < SKID_DEPTH).
  - The headroom of 2 covers the upstream's registered reaction.
  - Independent of LINK_STAGES, because in-flight flits are already counted.
- Push into a full FIFO:
  - The flit is dropped, the FIFO is unchanged, and overflow_o is set.
  - overflow_o is cleared only by reset.
- Output arbitration:
  - Eligible VC: FIFO[v] non-empty AND dn_on_off_i[v]=1.
  - Round-robin starting at the pointer; at most one pop per cycle.
  - Winner's head flit is registered onto dn_data_o with dn_valid_o=1 the next cycle.
  - Pointer moves to winner+1 mod VC_NUM; it does not move if no VC is eligible, in which case dn_valid_o=0 next cycle.
  - Push and pop of the same FIFO in one cycle are allowed, including when the FIFO is full (pop frees the slot first) or empty (no bypass: the flit becomes eligible the next cycle).
- Latency: minimum up_valid_i to dn_valid_o is LINK_STAGES+2 cycles.
- Reverse allocatable path:
  - dn_is_allocatable_i is delayed through LINK_STAGES registers.
  - up_is_allocatable_o[v] is registered as delayed[v] AND (cnt[v]==0); a VC is never advertised free while its flits remain in the link.
- Ordering: flits of the same VC leave in arrival order; no ordering guarantee across VCs.
- Flit fields are never modified.

Decomposition:
- noc_params (shared package): flit_t with its vc_id field, VC_NUM default, and new constants LINK_STAGES_DEFAULT and LINK_SKID_DEPTH_DEFAULT.
- Sub-module link_skid_fifo: single-VC circular FIFO, DEPTH parameter, push/pop/full/empty/head.
  - Instantiated VC_NUM times in a generate loop.
  - Pointers wrap modulo DEPTH; a separate occupancy counter distinguishes full from empty.

Test Plan:
- Latency: LINK_STAGES=2, single flit vc 0, dn_on_off_i=11 -> dn_valid_o exactly 4 cycles later, data bit-identical, overflow_o=0.
- Back-pressure: SKID_DEPTH=8, dn_on_off_i[1]=0, upstream model streams vc-1 flits obeying up_on_off_o -> up_on_off_o[1] falls once cnt reaches 6; FIFO peaks at <=8; no overflow. Release dn_on_off_i[1] -> all flits drain in order.
- Fairness: both FIFOs holding 4 flits, both on -> output alternates vc0,vc1,vc0,... (8 flits in 8 consecutive cycles). Set dn_on_off_i[0]=0 -> only vc1 issues.
- Allocatable: dn_is_allocatable_i[0] rises while 3 vc0 flits remain in the link -> up_is_allocatable_o[0] stays 0 until cnt[0]=0, then rises after LINK_STAGES+1 delay relative to the input, whichever is later.
- Overflow: upstream ignores on_off and sends 10 vc0 flits while dn_on_off_i[0]=0 -> overflow_o=1 and stays high; exactly 8 flits delivered after release.
- Reset: assert rst low mid-stream with 5 flits in flight -> outputs immediately at reset values; after deassertion no stale flit emerges; cnt=0 and up_on_off_o=all 1.
